// File: rtl/gray_step_arbiter_if.sv
// Signal bundle between the requesters, the gray_step_arbiter and the
// shared 3-bit gray counter. The arbiter side uses the slave modport.
interface gray_step_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int STEPW = 4
);
  logic [NREQ-1:0]       Req;
  logic [NREQ*STEPW-1:0] Steps;
  logic [NREQ-1:0]       Clr;
  logic [NREQ-1:0]       Gnt;
  logic [NREQ-1:0]       Done;
  logic                  Busy;
  logic                  OvfFlag;
  logic                  CntEn;
  logic                  CntReset;
  logic                  CntOverflow;

  modport master (
    output Req, Steps, Clr, CntOverflow,
    input  Gnt, Done, Busy, OvfFlag, CntEn, CntReset
  );

  modport slave (
    input  Req, Steps, Clr, CntOverflow,
    output Gnt, Done, Busy, OvfFlag, CntEn, CntReset
  );
endinterface

// File: rtl/gray_step_arbiter.sv
// Round-robin arbiter/sequencer sharing one gray counter between NREQ
// requesters. A granted requester gets an optional synchronous clear of
// the counter, then Steps increment cycles, then a one-cycle Done pulse
// carrying the counter's overflow status.
module gray_step_arbiter #(
  parameter int NREQ  = 4,
  parameter int STEPW = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  gray_step_arbiter_if.slave  bus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [IDXW-1:0]   ptr_r;
  logic [IDXW-1:0]   idx_r;
  logic [STEPW-1:0]  rem_r;
  logic [NREQ-1:0]   gnt_r;
  logic [NREQ-1:0]   done_r;
  logic              busy_r;
  logic              cnt_en_r;
  logic              cnt_reset_r;

  logic              found_s;
  logic [IDXW-1:0]   win_s;
  logic [IDXW-1:0]   cand_s;
  logic [STEPW-1:0]  win_steps_s;
  logic              win_clr_s;

  // One-hot vector with bit idx set.
  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin successor of idx, wrapping at NREQ.
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
    logic [IDXW-1:0] n;
    if (idx == IDXW'(NREQ - 1)) begin
      n = {IDXW{1'b0}};
    end else begin
      n = idx + {{(IDXW-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

  // Pick the first requester at or above Ptr (wrapping) and fetch its fields.
  always_comb begin
    found_s     = 1'b0;
    win_s       = {IDXW{1'b0}};
    cand_s      = {IDXW{1'b0}};
    win_steps_s = {STEPW{1'b0}};
    win_clr_s   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IDXW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && bus.Req[cand_s]) begin
        found_s     = 1'b1;
        win_s       = cand_s;
        win_steps_s = bus.Steps[int'(cand_s)*STEPW +: STEPW];
        win_clr_s   = bus.Clr[cand_s];
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Grant sequencer: all outputs are set on the edge that enters the state
  // they belong to, so every output below is a plain register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r     <= IDLE;
      ptr_r       <= {IDXW{1'b0}};
      idx_r       <= {IDXW{1'b0}};
      rem_r       <= {STEPW{1'b0}};
      gnt_r       <= {NREQ{1'b0}};
      done_r      <= {NREQ{1'b0}};
      busy_r      <= 1'b0;
      cnt_en_r    <= 1'b0;
      cnt_reset_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            idx_r  <= win_s;
            rem_r  <= win_steps_s;
            gnt_r  <= onehot(win_s);
            busy_r <= 1'b1;
            if (win_clr_s) begin
              state_r     <= CLEAR;
              cnt_reset_r <= 1'b1;
            end else if (win_steps_s != {STEPW{1'b0}}) begin
              state_r  <= STEP;
              cnt_en_r <= 1'b1;
            end else begin
              state_r <= DONE;
              done_r  <= onehot(win_s);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          cnt_reset_r <= 1'b0;
          if (rem_r != {STEPW{1'b0}}) begin
            state_r  <= STEP;
            cnt_en_r <= 1'b1;
          end else begin
            state_r <= DONE;
            done_r  <= onehot(idx_r);
          end
        end
        STEP: begin
          rem_r <= rem_r - {{(STEPW-1){1'b0}}, 1'b1};
          if (rem_r == {{(STEPW-1){1'b0}}, 1'b1}) begin
            state_r  <= DONE;
            cnt_en_r <= 1'b0;
            done_r   <= onehot(idx_r);
          end else begin
            state_r  <= STEP;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= {NREQ{1'b0}};
          gnt_r   <= {NREQ{1'b0}};
          busy_r  <= 1'b0;
          ptr_r   <= next_idx(idx_r);
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= {NREQ{1'b0}};
          done_r      <= {NREQ{1'b0}};
          busy_r      <= 1'b0;
          cnt_en_r    <= 1'b0;
          cnt_reset_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Gnt      = gnt_r;
  assign bus.Done     = done_r;
  assign bus.Busy     = busy_r;
  assign bus.CntEn    = cnt_en_r;
  assign bus.CntReset = cnt_reset_r;
  // The counter's sticky flag already reflects the final increment during
  // the DONE cycle; gating it with Done reports exactly that value.
  assign bus.OvfFlag  = (|done_r) & bus.CntOverflow;

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Bench for gray_step_arbiter: directed scenarios plus random traffic,
// checked every cycle against a grant-level reference model. The bench
// also plays the role of the shared 3-bit gray counter.
module tb_gray_step_arbiter;
  localparam int NREQ  = 4;
  localparam int STEPW = 4;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  gray_step_arbiter_if #(.NREQ(NREQ), .STEPW(STEPW)) bus ();

  gray_step_arbiter #(.NREQ(NREQ), .STEPW(STEPW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Shared counter: only its position mod 8 and sticky wrap flag matter.
  int   env_cnt = 0;
  logic env_ovf = 1'b0;
  always @(posedge Clk) begin
    if (bus.CntReset) begin
      env_cnt <= 0;
      env_ovf <= 1'b0;
    end else if (bus.CntEn) begin
      env_cnt <= (env_cnt + 1) % 8;
      if (env_cnt == 7) env_ovf <= 1'b1;
    end
  end
  assign bus.CntOverflow = env_ovf;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: one grant described by owner, position and length.
  bit m_active = 1'b0;
  int m_owner  = 0;
  int m_k      = 0;
  int m_len    = 0;
  int m_clr    = 0;
  int m_steps  = 0;
  int m_ptr    = 0;
  int m_cnt    = 0;
  bit m_ovf    = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check this cycle's outputs, then drive the inputs seen at the next edge
  // and advance the model across that edge.
  task automatic run_cycle(input logic rst_v, input logic [NREQ-1:0] req_v,
                           input logic [NREQ*STEPW-1:0] steps_v, input logic [NREQ-1:0] clr_v);
    logic [NREQ-1:0] e_gnt, e_done;
    bit e_busy, e_en, e_crst, e_ovf, found;
    @(negedge Clk);
    e_gnt  = m_active ? NREQ'(1 << m_owner) : '0;
    e_done = (m_active && m_k == m_len - 1) ? NREQ'(1 << m_owner) : '0;
    e_busy = m_active;
    e_crst = m_active && m_clr == 1 && m_k == 0;
    e_en   = m_active && m_k >= m_clr && m_k < m_clr + m_steps;
    e_ovf  = (e_done != '0) && m_ovf;
    chk_eq("gnt",    32'(bus.Gnt),      32'(e_gnt));
    chk_eq("done",   32'(bus.Done),     32'(e_done));
    chk_eq("busy",   32'(bus.Busy),     32'(e_busy));
    chk_eq("cnten",  32'(bus.CntEn),    32'(e_en));
    chk_eq("cntrst", 32'(bus.CntReset), 32'(e_crst));
    chk_eq("ovf",    32'(bus.OvfFlag),  32'(e_ovf));
    Reset     = rst_v;
    bus.Req   = req_v;
    bus.Steps = steps_v;
    bus.Clr   = clr_v;
    if (!rst_v) begin
      m_active = 1'b0;
      m_ptr    = 0;
    end else begin
      if (e_crst) begin
        m_cnt = 0;
        m_ovf = 1'b0;
      end else if (e_en) begin
        if (m_cnt == 7) m_ovf = 1'b1;
        m_cnt = (m_cnt + 1) % 8;
      end
      if (m_active) begin
        m_k++;
        if (m_k == m_len) begin
          m_active = 1'b0;
          m_ptr    = (m_owner + 1) % NREQ;
        end
      end else if (req_v != '0) begin
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_v[(m_ptr + i) % NREQ]) begin
            found   = 1'b1;
            m_owner = (m_ptr + i) % NREQ;
          end
        end
        m_active = 1'b1;
        m_k      = 0;
        m_clr    = clr_v[m_owner] ? 1 : 0;
        m_steps  = int'(steps_v[m_owner*STEPW +: STEPW]);
        m_len    = m_steps + 1 + m_clr;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b1, '0, '0, '0);
  endtask

  initial begin
    bus.Req   = '0;
    bus.Steps = '0;
    bus.Clr   = '0;

    // Reset held with every requester asking: nothing may come out.
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 4'b1111, 16'h1111, 4'b0000);
    // Release: requester 0 wins first (Steps=0, so a one-cycle grant).
    run_cycle(1'b1, 4'b1111, 16'h0000, 4'b0000);
    idle_cycles(4);

    // Requester 1 alone: clear, three increments, Done with no overflow.
    run_cycle(1'b1, 4'b0010, 16'h0030, 4'b0010);
    idle_cycles(8);

    // All four asking with Steps=1: rotating 0,1,2,3,0 with idle gaps.
    for (int i = 0; i < 14; i++) run_cycle(1'b1, 4'b1111, 16'h1111, 4'b0000);
    idle_cycles(4);

    // Requester 2: clear then eight increments wraps the counter.
    run_cycle(1'b1, 4'b0100, 16'h0800, 4'b0100);
    idle_cycles(12);

    // Requester 3 with Steps=0, no clear: grant and Done in the same cycle.
    run_cycle(1'b1, 4'b1000, 16'h0000, 4'b0000);
    idle_cycles(3);

    // Maximum step count without clear.
    run_cycle(1'b1, 4'b0001, 16'h000F, 4'b0000);
    idle_cycles(18);

    // Abort in the middle of STEP with an asynchronous reset.
    run_cycle(1'b1, 4'b0100, 16'h0A00, 4'b0000);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 4'b0000, 16'h0000, 4'b0000);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk_eq("arst_gnt",   32'(bus.Gnt),   32'd0);
    chk_eq("arst_cnten", 32'(bus.CntEn), 32'd0);
    chk_eq("arst_busy",  32'(bus.Busy),  32'd0);
    chk_eq("arst_done",  32'(bus.Done),  32'd0);
    m_active = 1'b0;
    m_ptr    = 0;
    run_cycle(1'b0, 4'b1111, 16'h2222, 4'b0000);
    // Restart: Ptr is back at 0, so requester 0 leads again.
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 4'b1111, 16'h2222, 4'b0000);
    idle_cycles(4);

    // Random traffic, including changes during grants and rare resets.
    for (int i = 0; i < 600; i++) begin
      run_cycle(($urandom_range(0, 149) != 0),
                NREQ'($urandom_range(0, 15)),
                (NREQ*STEPW)'($urandom),
                NREQ'($urandom_range(0, 15)));
    end
    idle_cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gray_step_arbiter.md
Name: gray_step_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 3-bit gray-code counter between NREQ requesters.
- Each requester asks for an optional counter clear followed by a number of increment steps.
- The block grants one requester at a time and drives the counter's enable and synchronous clear.
- It returns a per-requester done pulse together with the counter's overflow status at completion.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- STEPW, 4, width of each requester's step-count field.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  NREQ  per-requester request level.
- Steps  in  NREQ*STEPW  per-requester increment count. Requester i uses bits [i*STEPW +: STEPW].
- Clr  in  NREQ  per-requester "clear counter before stepping" flag.
- Gnt  out  NREQ  one-hot grant, registered.
- Done  out  NREQ  one-hot, one-cycle completion pulse, registered.
- Busy  out  1  high whenever the FSM is not in IDLE.
- OvfFlag  out  1  counter overflow status captured at completion; valid while any Done bit is high.
- CntEn  out  1  increment enable to the gray counter; active-high.
- CntReset  out  1  synchronous clear to the gray counter; active-high, one cycle.
- CntOverflow  in  1  sticky overflow from the gray counter. It is set on the 7->0 wrap and cleared by CntReset.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE, Ptr=0, latched index/steps/clear = 0. Outputs Gnt, Done, Busy, OvfFlag, CntEn, CntReset all = 0, and they drop immediately. Reset mid-transaction aborts it with no Done pulse.
- FSM states: IDLE, CLEAR, STEP, DONE.
- IDLE, arbitration:
  - If any Req bit is high at a rising edge, the winner is the first set bit searching upward from Ptr, wrapping modulo NREQ.
  - On that edge: latch the winner index, its Steps as Rem, and its Clr; set Gnt[winner]=1.
  - Next state: CLEAR if Clr=1; else STEP if Rem!=0; else DONE.
- CLEAR: CntReset=1 for exactly one cycle. Next state: STEP if Rem!=0, else DONE.
- STEP:
  - CntEn=1 every cycle in this state; Rem decrements on each edge.
  - When Rem==1 at an edge, next state is DONE.
  - CntEn is therefore high for exactly Steps consecutive cycles.
- DONE:
  - Done[idx]=1 for one cycle; OvfFlag=CntOverflow sampled at entry to DONE, i.e. counter state after the last increment. Gnt stays high.
  - On exit: Gnt=0, Ptr=(idx+1) mod NREQ, next state IDLE. At least one IDLE cycle occurs between grants.
- Gnt is high from the cycle after acceptance through the DONE cycle inclusive. Grant length is Steps+1 cycles, plus 1 if Clr=1.
- CntEn and CntReset are never high in the same cycle, and never high outside a grant.
- Req, Steps and Clr are sampled only at acceptance:
  - Changes during a grant are ignored.
  - Dropping Req mid-grant does not abort.
  - A Req still high after Done is re-arbitrated normally and ranks last because of Ptr rotation.
- Simultaneous requests resolve by Ptr order only. No requester waits more than NREQ-1 grants.
- Steps = all ones (15 at default) is legal: CntEn runs 15 cycles, which wraps the counter. OvfFlag=1 unless CntOverflow is cleared externally.
- Steps=0 with Clr=0 gives a 1-cycle grant: straight to DONE, CntEn never asserted.

Test Plan:
- Reset: hold Reset=0 while Req=4'b1111 -> all outputs 0. Release and Req0 wins first -> Gnt=0001 after one edge.
- Req1 only, Steps1=3, Clr1=1 -> CntReset high 1 cycle, then CntEn high 3 cycles, then Done=0010 for 1 cycle with OvfFlag=0. Gnt=0010 for 5 cycles; Busy drops the cycle after Done.
- Req=1111 held, all Steps=1, Clr=0 -> grant order 0,1,2,3,0; each Gnt lasts 2 cycles with one IDLE cycle between grants.
- Req2, Clr2=1, Steps2=8 (0->7 then wrap) -> 8 CntEn cycles, Done=0100 with OvfFlag=1 from the counter model.
- Steps=0, Clr=0 on Req3 -> Gnt=1000 for 1 cycle, Done=1000 in that same cycle, CntEn never high.
- Assert Reset=0 in the middle of STEP -> CntEn, Gnt and Busy drop asynchronously with no Done pulse. After release, Ptr=0 and arbitration restarts.
